// File: rtl/vc_arbiter_mux.sv
// vc_arbiter_mux: N-channel virtual-channel output multiplexer with arbiter.
// Each cycle one non-empty VC is chosen, by strict priority or by round robin. Its FIFO
// is popped combinationally and its head word is registered onto the link with a valid
// flag and a VC tag. A wrapping counter tracks the granted words.
module vc_arbiter_mux #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned NUM_VC    = 4,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned ID_W     = $clog2(NUM_VC)
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        mode,
    input  logic                        pause,
    input  logic [NUM_VC-1:0]           fifo_empty,
    input  logic [NUM_VC*DATA_SIZE-1:0] data_in,
    output logic [NUM_VC-1:0]           pop,
    output logic [DATA_SIZE-1:0]        data_out,
    output logic                        valid_out,
    output logic [ID_W-1:0]             vc_id_out,
    output logic [CNT_W-1:0]            xfer_count
);

    logic [NUM_VC-1:0]    eligible;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      rr_idx;
    logic [ID_W-1:0]      last_grant;
    logic [DATA_SIZE-1:0] words [NUM_VC];
    logic [DATA_SIZE-1:0] grant_word;

    // Unpack the flattened FIFO heads so that the selected word is a plain array index.
    always_comb begin
        for (int i = 0; i < int'(NUM_VC); i++) begin
            words[i] = data_in[i*int'(DATA_SIZE) +: DATA_SIZE];
        end
    end

    // Grant selection. The loops run from the far end so that the last match, which is
    // the nearest candidate, is the one that wins.
    always_comb begin
        eligible    = ~fifo_empty & {NUM_VC{~pause & reset_L}};
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        if (!mode) begin
            for (int i = int'(NUM_VC) - 1; i >= 0; i--) begin
                if (eligible[ID_W'(i)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(i);
                end
            end
        end else begin
            // The search begins at last_grant+1. The modulo keeps indices below NUM_VC
            // even when NUM_VC is not a power of two.
            for (int k = int'(NUM_VC); k >= 1; k--) begin
                rr_idx = ID_W'((int'(last_grant) + k) % int'(NUM_VC));
                if (eligible[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx;
                end
            end
        end
    end

    // Pop strobe: one-hot of the grant, or zero when nothing is eligible.
    always_comb begin
        pop = '0;
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
        grant_word = words[grant_idx];
    end

    // Registered output path and arbitration state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            vc_id_out  <= '0;
            xfer_count <= '0;
            // Reset the pointer to the top VC so that the first round-robin grant goes to VC0.
            last_grant <= ID_W'(NUM_VC - 1);
        end else if (grant_valid) begin
            data_out   <= grant_word;
            valid_out  <= 1'b1;
            vc_id_out  <= grant_idx;
            xfer_count <= xfer_count + CNT_W'(1);
            last_grant <= grant_idx;
        end else begin
            data_out   <= '0;
            valid_out  <= 1'b0;
        end
    end

    // At most one FIFO is popped in any cycle.
    pop_onehot0: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(pop));

endmodule

// File: doc/vc_arbiter_mux.md
Name: vc_arbiter_mux

Overview:
- Parametrised N-channel virtual-channel output multiplexer with arbiter.
- Sits between the per-VC FIFOs and the downstream link.
- Each cycle it picks one non-empty VC, drives that VC's pop, and registers the selected word onto the output with a valid flag and a VC tag.
- Supports strict-priority and round-robin arbitration, downstream pause (backpressure) and a transfer counter.

Parameters:
- DATA_SIZE, 6, word width per VC.
- NUM_VC, 4, number of virtual channels, legal range 2..16.
- CNT_W, 8, width of the transfer counter.
- Derived localparam ID_W = $clog2(NUM_VC).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous active-low reset.
- mode  input  1  0 = strict priority (lowest index wins), 1 = round robin.
- pause  input  1  downstream almost-full; while high no grant is issued.
- fifo_empty  input  NUM_VC  bit i high = VC i FIFO empty.
- data_in  input  NUM_VC*DATA_SIZE  flattened FIFO heads; VC i word = data_in[i*DATA_SIZE +: DATA_SIZE]; first-word-fall-through, valid in the same cycle as !fifo_empty[i].
- pop  output  NUM_VC  one-hot-or-zero pop strobe to the FIFOs (combinational).
- data_out  output  DATA_SIZE  registered selected word.
- valid_out  output  1  registered; high for exactly the cycle data_out carries a popped word.
- vc_id_out  output  ID_W  registered index of the VC that produced data_out.
- xfer_count  output  CNT_W  registered count of granted words since reset.

Behaviour:
- Eligibility: VC i is eligible when !fifo_empty[i] && !pause && reset_L.
- Priority mode (mode=0): the grant goes to the lowest-index eligible VC.
- Round-robin mode (mode=1): search starts at (last_grant+1) mod NUM_VC, wraps, and grants the first eligible VC.
- last_grant:
  - Updates only on a cycle with a grant, in either mode.
  - It is not cleared by a mode change.
  - A mode change takes effect in the same cycle mode is sampled.
- pop is combinational: pop = one-hot of the grant, or all zeros if no VC is eligible. Never more than one bit high.
- pop is forced to 0 while reset_L is low or pause is high.
- Registered path (rising clk):
  - Grant to VC g: data_out <= word g, vc_id_out <= g, valid_out <= 1, xfer_count <= xfer_count+1.
  - No grant: valid_out <= 0, data_out <= 0, vc_id_out holds, xfer_count holds.
- Latency: one cycle from pop to valid_out/data_out.
- Throughput: one word per cycle, sustained.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (asynchronous, reset_L low):
  - Registered outputs: data_out=0, valid_out=0, vc_id_out=0, xfer_count=0.
  - last_grant=NUM_VC-1, so the first round-robin grant after reset goes to VC0.
- Reset deasserted mid-stream: the first eligible cycle behaves exactly as after a fresh reset. Words popped before reset are not replayed.
- Pause timing:
  - pause rising: no pop in that same cycle; valid_out is low the next cycle.
  - pause falling: the grant resumes in the same cycle, with round-robin pointer state preserved.
- All VCs empty: no pop; valid_out low next cycle; state held.
- A VC that becomes empty in the cycle it would win is simply not eligible. No speculative pop.
- Arithmetic: the round-robin wrap uses modulo NUM_VC, correct for non-power-of-2 NUM_VC (e.g. 3 or 5). Indices ≥ NUM_VC are never produced.

Test Plan (NUM_VC=4, DATA_SIZE=6 unless stated):
1. Reset then priority: mode=0, fifo_empty=4'b0000, heads 0x11/0x12/0x13/0x14 held -> pop=4'b0001 every cycle; each next cycle data_out=0x11, vc_id_out=0, valid_out=1; xfer_count 1,2,3...
2. Round robin: mode=1, all VCs non-empty -> pop sequence 0001,0010,0100,1000,0001; vc_id_out 0,1,2,3,0 one cycle later. With fifo_empty=4'b0101 -> grants alternate VC1, VC3.
3. Pause: mode=1, all non-empty, pause high for cycles 5-7 -> pop=0 in cycles 5-7, valid_out=0 and data_out=0 in cycles 6-8; if VC2 was last granted in cycle 4, cycle 8 grants VC3.
4. Empty/edge: fifo_empty=4'b1111 -> pop=0, valid_out=0. A single VC2 non-empty for one cycle -> exactly one pop[2] and one valid_out pulse with vc_id_out=2.
5. Async reset mid-stream: reset_L low between clock edges during a round-robin burst -> outputs go to 0 immediately without a clock edge; after release the first round-robin grant is VC0; xfer_count restarts at 1.
6. Parameter corners: NUM_VC=3 with CNT_W=2 and round robin, all non-empty -> grant sequence 0,1,2,0; xfer_count 1,2,3,0. Mode switched 1->0 mid-run -> the next grant is the lowest-index eligible VC.
